// File: rtl/pos_sweep_pkg.sv
// pos_sweep_pkg: shared FSM state and maxterm slot types for the POS sweep engine
// Slot masks are sized for the widest supported N_IN; narrower instances keep upper bits zero.
package pos_sweep_pkg;
  localparam int N_IN_MAX = 8;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  typedef struct packed {
    logic                en;
    logic [N_IN_MAX-1:0] use_mask;
    logic [N_IN_MAX-1:0] neg_mask;
  } term_t;
endpackage

// File: rtl/pos_sweep_engine_eval.sv
// pos_eval: combinational product-of-sums evaluator over a maxterm table
// Ports: vec_i input vector, tbl_i slot table, f_o = AND of enabled term sums (1 when none enabled).
module pos_eval
  import pos_sweep_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int N_TERMS = 8
) (
  input  logic [N_IN-1:0] vec_i,
  input  term_t           tbl_i [N_TERMS],
  output logic            f_o
);
  logic [N_IN_MAX-1:0] x;
  // A literal is x ^ neg; a term with an empty use mask sums to 0.
  always_comb begin
    x = N_IN_MAX'(vec_i);
    f_o = 1'b1;
    for (int k = 0; k < N_TERMS; k++)
      f_o = f_o & (~tbl_i[k].en | (|(tbl_i[k].use_mask & (x ^ tbl_i[k].neg_mask))));
  end
endmodule

// File: rtl/pos_sweep_engine.sv
// pos_sweep_engine: programmable POS engine with registered direct path and truth-table sweep
// Ports: cfg_* write one slot in IDLE; eval_in/eval_f direct path (1-cycle latency);
// start launches a sweep streamed on out_valid/out_ready/out_vec/out_f/out_last;
// ones_count tallies accepted ones; done pulses after the last row; busy is high while sweeping.
module pos_sweep_engine
  import pos_sweep_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int N_TERMS = 8
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            cfg_we,
  input  logic [((N_TERMS > 1) ? $clog2(N_TERMS) : 1)-1:0] cfg_idx,
  input  logic                                            cfg_en,
  input  logic [N_IN-1:0]                                 cfg_use,
  input  logic [N_IN-1:0]                                 cfg_neg,
  input  logic [N_IN-1:0]                                 eval_in,
  output logic                                            eval_f,
  input  logic                                            start,
  output logic                                            busy,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [N_IN-1:0]                                 out_vec,
  output logic                                            out_f,
  output logic                                            out_last,
  output logic [N_IN:0]                                   ones_count,
  output logic                                            done
);
  localparam int CW = N_IN + 1;
  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN:0]   ones_q, ones_d;
  logic            eval_f_q;
  term_t           tbl_q [N_TERMS];
  term_t           tbl_d [N_TERMS];
  logic            f_direct, f_sweep, last;
  pos_eval #(.N_IN(N_IN), .N_TERMS(N_TERMS)) u_direct (.vec_i(eval_in), .tbl_i(tbl_q), .f_o(f_direct));
  pos_eval #(.N_IN(N_IN), .N_TERMS(N_TERMS)) u_sweep  (.vec_i(vec_q),   .tbl_i(tbl_q), .f_o(f_sweep));
  assign last       = &vec_q;
  assign busy       = (state_q == SWEEP);
  assign out_valid  = busy;
  assign out_vec    = vec_q;
  assign out_f      = busy & f_sweep;
  assign out_last   = busy & last;
  assign done       = (state_q == DONE);
  assign ones_count = ones_q;
  assign eval_f     = eval_f_q;
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    ones_d  = ones_q;
    tbl_d   = tbl_q;
    // Indices at or beyond N_TERMS never match a slot, so they are dropped.
    for (int k = 0; k < N_TERMS; k++)
      if (state_q == IDLE && cfg_we && 32'(cfg_idx) == k)
        tbl_d[k] = '{en: cfg_en, use_mask: N_IN_MAX'(cfg_use), neg_mask: N_IN_MAX'(cfg_neg)};
    case (state_q)
      IDLE: if (start) begin
        state_d = SWEEP;
        vec_d   = '0;
        ones_d  = '0;
      end
      SWEEP: if (out_ready) begin
        ones_d  = ones_q + CW'(f_sweep);
        state_d = last ? DONE : SWEEP;
        vec_d   = last ? vec_q : vec_q + N_IN'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      ones_q   <= '0;
      eval_f_q <= 1'b0;
      tbl_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      ones_q   <= ones_d;
      eval_f_q <= f_direct;
      tbl_q    <= tbl_d;
    end
  end
endmodule

// File: tb/tb_pos_sweep_engine.sv
// tb_pos_sweep_engine: randomized and directed checks of pos_sweep_engine against a truth-table model
module tb_pos_sweep_engine;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_we = 0, cfg_en = 0, start = 0, out_ready = 0;
  logic [2:0] cfg_idx = '0;
  logic [3:0] cfg_use = '0, cfg_neg = '0, eval_in = '0;
  logic eval_f, busy, out_valid, out_f, out_last, done;
  logic [3:0] out_vec;
  logic [4:0] ones_count;
  logic b_cfg_we = 0, b_cfg_en = 0, b_start = 0, b_out_ready = 0;
  logic [0:0] b_cfg_idx = '0;
  logic [1:0] b_cfg_use = '0, b_cfg_neg = '0, b_eval_in = '0;
  logic b_eval_f, b_busy, b_out_valid, b_out_f, b_out_last, b_done;
  logic [1:0] b_out_vec;
  logic [2:0] b_ones;
  int checks = 0, errors = 0;
  bit m_en [8];
  logic [3:0] m_use [8];
  logic [3:0] m_neg [8];

  always #5 clk = ~clk;

  pos_sweep_engine #(.N_IN(4), .N_TERMS(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_use(cfg_use), .cfg_neg(cfg_neg), .eval_in(eval_in), .eval_f(eval_f),
    .start(start), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_f(out_f), .out_last(out_last), .ones_count(ones_count), .done(done));

  pos_sweep_engine #(.N_IN(2), .N_TERMS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_we(b_cfg_we), .cfg_idx(b_cfg_idx), .cfg_en(b_cfg_en),
    .cfg_use(b_cfg_use), .cfg_neg(b_cfg_neg), .eval_in(b_eval_in), .eval_f(b_eval_f),
    .start(b_start), .busy(b_busy), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_vec(b_out_vec), .out_f(b_out_f), .out_last(b_out_last), .ones_count(b_ones), .done(b_done));

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Product over enabled slots of the OR of the selected literals.
  function automatic bit model_f(input int v);
    bit f = 1'b1;
    for (int k = 0; k < 8; k++) if (m_en[k]) begin
      bit s = 1'b0;
      for (int i = 0; i < 4; i++) if (m_use[k][i]) s = s | (m_neg[k][i] ? !v[i] : v[i]);
      f = f & s;
    end
    return f;
  endfunction

  function automatic int model_ones();
    int n = 0;
    for (int v = 0; v < 16; v++) n += int'(model_f(v));
    return n;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 8; k++) begin
      m_en[k] = 0; m_use[k] = '0; m_neg[k] = '0;
    end
  endfunction

  task automatic wr(input int idx, input bit en, input logic [3:0] u, input logic [3:0] n);
    cfg_we = 1; cfg_idx = 3'(idx); cfg_en = en; cfg_use = u; cfg_neg = n;
    tick;
    cfg_we = 0;
    m_en[idx] = en; m_use[idx] = u; m_neg[idx] = n;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  // rnd: random out_ready; stall_row: hold ready low 3 cycles there;
  // inj_row: pulse ignored cfg_we/start there; abort_row: assert reset there.
  task automatic sweep(input bit rnd, input int stall_row, input int inj_row, input int abort_row, input int exp_ones);
    int r = 0, cnt = 0, cyc = 0, stall_left = 3;
    bit rdy, injected = 0;
    start = 1;
    tick;
    start = 0;
    cfg_we = 0;
    while (r < 16 && cyc < 200) begin
      cyc++;
      chk("sw_busy", 32'(busy), 1);
      chk("sw_valid", 32'(out_valid), 1);
      chk("sw_vec", 32'(out_vec), 32'(r));
      chk("sw_f", 32'(out_f), 32'(model_f(r)));
      chk("sw_last", 32'(out_last), 32'(r == 15));
      chk("sw_ones", 32'(ones_count), 32'(cnt));
      chk("sw_done", 32'(done), 0);
      if (r == abort_row) begin
        rst_n = 0;
        tick;
        rst_n = 1;
        model_clear();
        chk("ab_busy", 32'(busy), 0);
        chk("ab_valid", 32'(out_valid), 0);
        chk("ab_ones", 32'(ones_count), 0);
        chk("ab_vec", 32'(out_vec), 0);
        chk("ab_done", 32'(done), 0);
        tick;
        check_idle_outputs("ab_after");
        out_ready = 0;
        return;
      end
      if (rnd) rdy = 1'($urandom_range(0, 1));
      else if (r == stall_row && stall_left > 0) begin
        rdy = 0;
        stall_left--;
      end else rdy = 1;
      out_ready = rdy;
      if (r == inj_row && !injected) begin
        injected = 1;
        cfg_we = 1; cfg_idx = 3'd6; cfg_en = 1; cfg_use = '0; cfg_neg = '0;
        start = 1;
      end
      tick;
      cfg_we = 0;
      start = 0;
      if (rdy) begin
        cnt += int'(model_f(r));
        r++;
      end
    end
    out_ready = 0;
    chk("sw_rows_done", 32'(r), 16);
    chk("dn_done", 32'(done), 1);
    chk("dn_busy", 32'(busy), 0);
    chk("dn_valid", 32'(out_valid), 0);
    chk("dn_ones", 32'(ones_count), 32'(exp_ones));
    tick;
    chk("dn_pulse_end", 32'(done), 0);
    chk("dn_ones_hold", 32'(ones_count), 32'(exp_ones));
    tick;
    chk("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    logic [3:0] b_exp = 4'b1011;
    model_clear();
    tick;
    chk("rst_eval_f", 32'(eval_f), 0);
    chk("rst_vec", 32'(out_vec), 0);
    chk("rst_f", 32'(out_f), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_ones", 32'(ones_count), 0);
    check_idle_outputs("rst");
    rst_n = 1;
    eval_in = 4'b0101;
    tick;
    chk("empty_eval_f", 32'(eval_f), 1);
    check_idle_outputs("post_rst");
    chk("post_rst_ones", 32'(ones_count), 0);
    wr(0, 1, 4'b0111, 4'b0000);
    wr(1, 1, 4'b0011, 4'b0001);
    wr(2, 1, 4'b1101, 4'b0001);
    wr(3, 1, 4'b1110, 4'b1110);
    wr(4, 1, 4'b0111, 4'b0110);
    wr(5, 1, 4'b1011, 4'b1010);
    for (int n = 0; n < 20; n++) begin
      eval_in = 4'($urandom_range(0, 15));
      tick;
      chk("direct_f", 32'(eval_f), 32'(model_f(int'(eval_in))));
    end
    sweep(0, -1, -1, -1, 5);
    sweep(0, 3, -1, -1, 5);
    sweep(0, -1, 5, -1, 5);
    wr(6, 1, 4'b0000, 4'b0000);
    sweep(0, -1, -1, -1, 0);
    cfg_we = 1; cfg_idx = 3'd6; cfg_en = 0; cfg_use = '0; cfg_neg = '0;
    m_en[6] = 0;
    sweep(0, -1, -1, -1, 5);
    sweep(0, -1, -1, 9, 0);
    sweep(0, -1, -1, -1, 16);
    for (int round = 0; round < 3; round++) begin
      for (int k = 0; k < 8; k++)
        wr(k, $urandom_range(0, 2) == 0, 4'($urandom), 4'($urandom));
      for (int n = 0; n < 6; n++) begin
        eval_in = 4'($urandom_range(0, 15));
        tick;
        chk("rnd_direct_f", 32'(eval_f), 32'(model_f(int'(eval_in))));
      end
      sweep(1, -1, -1, -1, model_ones());
    end
    b_cfg_we = 1; b_cfg_idx = 1'b1; b_cfg_en = 1; b_cfg_use = '0; b_cfg_neg = '0;
    tick;
    b_cfg_idx = 1'b0; b_cfg_use = 2'b11; b_cfg_neg = 2'b10;
    tick;
    b_cfg_we = 0;
    b_start = 1;
    tick;
    b_start = 0;
    b_out_ready = 1;
    for (int r = 0; r < 4; r++) begin
      chk("b_vec", 32'(b_out_vec), 32'(r));
      chk("b_f", 32'(b_out_f), 32'(b_exp[r]));
      chk("b_last", 32'(b_out_last), 32'(r == 3));
      tick;
    end
    b_out_ready = 0;
    chk("b_done", 32'(b_done), 1);
    chk("b_ones", 32'(b_ones), 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pos_sweep_engine.md
# pos_sweep_engine

Parametrised, clocked product-of-sums logic engine. A programmable table of up to N_TERMS maxterms over N_IN inputs replaces fixed NOR-NOR gate networks. The block offers two evaluation paths. A direct path gives a registered F for an applied input vector. A sweep mode walks all 2^N_IN input combinations and streams the truth table out over a valid/ready handshake, counting the ones as it goes. It sits beside the combinational logic-function blocks as their reusable, self-checking successor.

## Interface
- N_IN, 4, number of function inputs (1..8); vector bit N_IN-1 is the MSB (A)
- N_TERMS, 8, number of maxterm slots (>=1)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous and active-low
- cfg_we  in  1  write one term slot
- cfg_idx  in  $clog2(N_TERMS) (min 1)  slot index
- cfg_en  in  1  slot participates in the product
- cfg_use  in  N_IN  bit i=1: input i appears in the sum
- cfg_neg  in  N_IN  bit i=1: literal is complemented (x')
- eval_in  in  N_IN  direct-mode input vector
- eval_f  out  1  registered F(eval_in)
- start  in  1  begin a sweep
- busy  out  1  high in SWEEP
- out_valid  out  1  truth-table row available
- out_ready  in  1  consumer accepts the row
- out_vec  out  N_IN  row input vector
- out_f  out  1  F(out_vec)
- out_last  out  1  row is 2^N_IN-1
- ones_count  out  N_IN+1  number of accepted rows with out_f=1
- done  out  1  one-cycle pulse after the last row is accepted

## Operation
- Term sum s_k = OR over i with use[i] of (neg[i] ? ~x[i] : x[i]). A term with use=0 but en=1 sums to 0, which forces F=0.
- F = AND of s_k over enabled slots. With no enabled slots, F=1 (empty product).
- Configuration: when cfg_we=1 in IDLE, slot cfg_idx takes {cfg_en, cfg_use, cfg_neg} at the clock edge. cfg_we is ignored in SWEEP and DONE. An index >= N_TERMS is ignored.
- Direct path is always active. eval_f is F of eval_in, registered, and uses the table contents as they stand before the edge.
- FSM states:
  - IDLE: busy=0, out_valid=0. start=1 moves to SWEEP, sets vec=0 and clears ones_count to 0.
  - SWEEP: busy=1, out_valid=1. On out_valid&out_ready: if out_f=1, ones_count increments. Then, if vec is not the last row, vec increments; if it is the last row, the FSM moves to DONE.
  - DONE: done=1 and busy=0 for one cycle, then the FSM returns to IDLE.
- start is ignored outside IDLE.
- ones_count holds its value after DONE until the next start.
- Backpressure: while out_valid=1 and out_ready=0, out_vec, out_f and out_last stay stable.
- Reset clears every slot to en=0, use=0 and neg=0, and returns the FSM to IDLE.

## Timing
- Reset values: eval_f=0, busy=0, out_valid=0, out_vec=0, out_f=0, out_last=0, ones_count=0, done=0; state=IDLE.
- eval_f latency is 1 cycle.
- Sweep rows: start is sampled in IDLE at edge t. Row 0 is presented at t+1.
- out_f is combinational from the registered vec and the table; the table is frozen during a sweep.
- Full sweep with out_ready held at 1: rows appear at t+1 .. t+2^N_IN, done pulses at t+2^N_IN+1, and the FSM is back in IDLE at t+2^N_IN+2.
- Reset asserted mid-sweep: at the next edge, all outputs return to their reset values, the sweep is abandoned, and no done pulse is issued.
- start and cfg_we in the same IDLE cycle: both take effect, so the sweep uses the newly written slot.

## Structure
- pos_sweep_pkg holds:
  - state enum {IDLE, SWEEP, DONE}
  - term_t struct {en, use[N_IN], neg[N_IN]}, sized by package parameter defaults
- Sub-module pos_eval: a purely combinational evaluator (vector plus table in, F out). It is instanced twice in the top: once for the direct path and once for the sweep path.

## Test plan
- Reset, then eval_in=4'b0101: eval_f=1 one cycle later (empty table). All other outputs at their reset values.
- N_IN=4. Program slots 0..5 as (B+C+D), (C+D'), (A+B+D'), (A'+B'+C'), (B'+C'+D), (A'+C'+D). Sweep with out_ready=1: out_f=1 only at rows 2, 4, 7, 11 and 12; out_last=1 only at row 15; ones_count=5; done pulses once.
- Same table, with out_ready low for 3 cycles while row 3 is presented: out_vec stays 3 and ones_count is unchanged. The sweep then completes with ones_count=5.
- During a sweep, pulse cfg_we (slot 6, en=1, use=0) and start: neither has any effect. After DONE, the same write forces a re-sweep to give ones_count=0.
- Assert rst_n=0 at row 9: busy=0, out_valid=0 and ones_count=0 next cycle, with no done pulse. A following sweep on the empty table gives ones_count=16.
- N_IN=2, N_TERMS=1, slot 0 = (A'+B): rows 0..3 give out_f=1,1,0,1 and ones_count=3.
